// File: rtl/mem_port_arbiter_if.sv
// Bundle between the fetch/load-store requesters, the shared memory and the arbiter.
// The arbiter takes the slave view; the requester/memory environment takes the master view.
interface mem_port_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_rvalid;
    logic [DATA_W-1:0]     if_rdata;
    logic                  flush_if;
    logic                  ls_req;
    logic                  ls_wren;
    logic [ADDR_W-1:0]     ls_addr;
    logic [DATA_W-1:0]     ls_wdata;
    logic [DATA_W/8-1:0]   ls_bmask;
    logic                  ls_gnt;
    logic                  ls_rvalid;
    logic [DATA_W-1:0]     ls_rdata;
    logic                  mem_req;
    logic                  mem_wren;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_bmask;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  stall_if;
    logic                  stall_ls;

    modport slave (
        input  if_req, if_addr, flush_if,
        input  ls_req, ls_wren, ls_addr, ls_wdata, ls_bmask,
        input  mem_rdata,
        output if_gnt, if_rvalid, if_rdata,
        output ls_gnt, ls_rvalid, ls_rdata,
        output mem_req, mem_wren, mem_addr, mem_wdata, mem_bmask,
        output stall_if, stall_ls
    );

    modport master (
        output if_req, if_addr, flush_if,
        output ls_req, ls_wren, ls_addr, ls_wdata, ls_bmask,
        output mem_rdata,
        input  if_gnt, if_rvalid, if_rdata,
        input  ls_gnt, ls_rvalid, ls_rdata,
        input  mem_req, mem_wren, mem_addr, mem_wdata, mem_bmask,
        input  stall_if, stall_ls
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Single-port fixed-latency memory shared by instruction fetch and load/store.
// state | meaning: IDLE | free, arbitrate this cycle;  BUSY | one access in flight, waiting MEM_LAT
module mem_port_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    mem_port_if.slave  bus
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);
    localparam int STK_W = $clog2(STARVE_MAX + 1);

    typedef enum logic {S_IDLE, S_BUSY} state_e;
    typedef enum logic {OWN_IF, OWN_LS} owner_e;

    state_e             state_q, state_d;
    owner_e             owner_q, owner_d;
    logic [CNT_W-1:0]   lat_cnt_q, lat_cnt_d;
    logic               killed_q, killed_d;
    logic [STK_W-1:0]   streak_q, streak_d;

    logic               if_gnt, ls_gnt, if_rvalid, ls_rvalid;
    logic               mem_req, mem_wren;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata;
    logic [DATA_W/8-1:0] mem_bmask;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q   <= S_IDLE;
            owner_q   <= OWN_IF;
            lat_cnt_q <= '0;
            killed_q  <= 1'b0;
            streak_q  <= '0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            lat_cnt_q <= lat_cnt_d;
            killed_q  <= killed_d;
            streak_q  <= streak_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        lat_cnt_d = lat_cnt_q;
        killed_d  = killed_q;
        streak_d  = streak_q;
        if_gnt    = 1'b0;
        ls_gnt    = 1'b0;
        if_rvalid = 1'b0;
        ls_rvalid = 1'b0;
        mem_req   = 1'b0;
        mem_wren  = 1'b0;
        mem_addr  = bus.ls_addr;
        mem_wdata = bus.ls_wdata;
        mem_bmask = bus.ls_bmask;

        case (state_q)
            S_IDLE: begin
                // Grants are suppressed while reset is asserted so nothing leaks out that cycle.
                if (!i_reset) begin
                    if (bus.ls_req && (!bus.if_req || streak_q != STK_W'(STARVE_MAX))) begin
                        ls_gnt    = 1'b1;
                        mem_req   = 1'b1;
                        mem_wren  = bus.ls_wren;
                        owner_d   = OWN_LS;
                        state_d   = S_BUSY;
                        lat_cnt_d = CNT_W'(1);
                        killed_d  = 1'b0;
                        if (!bus.if_req)
                            streak_d = '0;
                        else if (streak_q != STK_W'(STARVE_MAX))
                            streak_d = streak_q + STK_W'(1);
                    end else if (bus.if_req) begin
                        if_gnt    = 1'b1;
                        mem_req   = 1'b1;
                        mem_addr  = bus.if_addr;
                        mem_wdata = '0;
                        mem_bmask = '0;
                        owner_d   = OWN_IF;
                        state_d   = S_BUSY;
                        lat_cnt_d = CNT_W'(1);
                        killed_d  = 1'b0;
                        streak_d  = '0;
                    end
                end
            end
            S_BUSY: begin
                if (owner_q == OWN_IF && bus.flush_if)
                    killed_d = 1'b1;
                if (lat_cnt_q == CNT_W'(MEM_LAT)) begin
                    state_d   = S_IDLE;
                    lat_cnt_d = '0;
                    if (owner_q == OWN_LS)
                        ls_rvalid = !i_reset;
                    else
                        if_rvalid = !i_reset && !killed_q && !bus.flush_if;
                end else begin
                    lat_cnt_d = lat_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.if_gnt    = if_gnt;
    assign bus.ls_gnt    = ls_gnt;
    assign bus.if_rvalid = if_rvalid;
    assign bus.ls_rvalid = ls_rvalid;
    assign bus.if_rdata  = bus.mem_rdata;
    assign bus.ls_rdata  = bus.mem_rdata;
    assign bus.mem_req   = mem_req;
    assign bus.mem_wren  = mem_wren;
    assign bus.mem_addr  = mem_addr;
    assign bus.mem_wdata = mem_wdata;
    assign bus.mem_bmask = mem_bmask;
    assign bus.stall_if  = bus.if_req & ~if_rvalid;
    assign bus.stall_ls  = bus.ls_req & ~ls_rvalid;
endmodule
